// File: rtl/msgpass_rqst_writer_if.sv
// Request-word handshake between a producer and the message-pass buffer writer.
interface msgpass_rqst_writer_if #(
    parameter int SHARE_GROUP_SIZE   = 5,
    parameter int RQST_ADDR_BITWIDTH = 3
);
    logic                                         rqst_valid_i;
    logic                                         rqst_ready_o;
    logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_addr_i;
    logic [SHARE_GROUP_SIZE-1:0]                  rqst_lane_mask_i;

    modport master (
        output rqst_valid_i, rqst_addr_i, rqst_lane_mask_i,
        input  rqst_ready_o
    );

    modport slave (
        input  rqst_valid_i, rqst_addr_i, rqst_lane_mask_i,
        output rqst_ready_o
    );
endinterface

// File: rtl/msgpass_rqst_writer.sv
// Producer-side writer for the message-pass buffer: packs request words into rows,
// drives write port A and tracks row occupancy against reader pops.
module msgpass_rqst_lane_pack #(
    parameter int W = 3
) (
    input  logic [W-1:0] addr,
    input  logic         vld,
    output logic [W:0]   lane
);
    assign lane = {vld, vld ? addr : {W{1'b0}}};
endmodule

module msgpass_rqst_writer #(
    parameter int SHARE_GROUP_SIZE        = 5,
    parameter int RQST_ADDR_BITWIDTH      = 3,
    parameter int MSGPASS_BUFF_RQST_WIDTH = RQST_ADDR_BITWIDTH + 1,
    parameter int MSGPASS_BUFF_DEPTH      = 8,
    parameter int MSGPASS_BUFF_ADDR_WIDTH = $clog2(MSGPASS_BUFF_DEPTH),
    parameter int CNT_WIDTH               = 8
) (
    input  logic                                              sys_clk,
    input  logic                                              rst,
    msgpass_rqst_writer_if.slave                              rqst,
    input  logic                                              frame_begin_i,
    input  logic                                              frame_end_i,
    input  logic                                              rd_pop_i,
    output logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]                waddr_portA_o,
    output logic [SHARE_GROUP_SIZE*MSGPASS_BUFF_RQST_WIDTH-1:0] wdata_portA_o,
    output logic                                              wen_portA_o,
    output logic                                              full_o,
    output logic                                              empty_o,
    output logic                                              frame_done_o,
    output logic [CNT_WIDTH-1:0]                              entry_cnt_o,
    output logic                                              underflow_err_o
);
    localparam int ROW_W = SHARE_GROUP_SIZE * MSGPASS_BUFF_RQST_WIDTH;
    localparam int OCC_W = $clog2(MSGPASS_BUFF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [MSGPASS_BUFF_ADDR_WIDTH-1:0] addr;
        logic [ROW_W-1:0]                   data;
    } wr_req_t;

    state_t state, state_nxt;
    logic   frame_start;

    logic [MSGPASS_BUFF_ADDR_WIDTH-1:0] wptr;
    logic [OCC_W-1:0]                   occ, occ_nxt;
    logic                               accept, pop_ok;
    wr_req_t                            wr_q;

    logic [SHARE_GROUP_SIZE-1:0][RQST_ADDR_BITWIDTH-1:0]      lane_addr;
    logic [SHARE_GROUP_SIZE-1:0][MSGPASS_BUFF_RQST_WIDTH-1:0] row;

    assign lane_addr = rqst.rqst_addr_i;

    genvar g;
    generate
        for (g = 0; g < SHARE_GROUP_SIZE; g++) begin : g_lane
            msgpass_rqst_lane_pack #(.W(RQST_ADDR_BITWIDTH)) u_pack (
                .addr (lane_addr[g]),
                .vld  (rqst.rqst_lane_mask_i[g]),
                .lane (row[g])
            );
        end
    endgenerate

    // Ready comes only from registered state so a producer may wait on it before raising valid.
    assign rqst.rqst_ready_o = (state == ACTIVE) && !full_o;
    assign accept            = rqst.rqst_valid_i && rqst.rqst_ready_o;
    assign pop_ok            = rd_pop_i && (occ != '0);
    assign frame_done_o      = (state == DONE);

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                if (frame_begin_i) begin
                    state_nxt   = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE:  if (frame_end_i) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        occ_nxt = occ;
        case ({accept, pop_ok})
            2'b10:   occ_nxt = occ + 1'b1;
            2'b01:   occ_nxt = occ - 1'b1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            occ             <= '0;
            full_o          <= 1'b0;
            empty_o         <= 1'b1;
            underflow_err_o <= 1'b0;
        end else begin
            occ     <= occ_nxt;
            full_o  <= (occ_nxt == OCC_W'(MSGPASS_BUFF_DEPTH));
            empty_o <= (occ_nxt == '0);
            if (rd_pop_i && (occ == '0)) underflow_err_o <= 1'b1;
        end
    end

    // wptr and the frame counter restart per frame; occupancy spans frames.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            entry_cnt_o <= '0;
        end else if (frame_start) begin
            wptr        <= '0;
            entry_cnt_o <= '0;
        end else if (accept) begin
            wptr <= (wptr == MSGPASS_BUFF_ADDR_WIDTH'(MSGPASS_BUFF_DEPTH - 1))
                    ? '0 : wptr + 1'b1;
            if (!(&entry_cnt_o)) entry_cnt_o <= entry_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wen_portA_o <= 1'b1;
            wr_q        <= '0;
        end else begin
            wen_portA_o <= !accept;
            if (accept) begin
                wr_q.addr <= wptr;
                wr_q.data <= row;
            end
        end
    end

    assign waddr_portA_o = wr_q.addr;
    assign wdata_portA_o = wr_q.data;
endmodule

// File: doc/msgpass_rqst_writer.md
Name: msgpass_rqst_writer

Overview:
- Producer-side writer for the message-pass buffer.
- Accepts per-cycle access-request words (SHARE_GROUP_SIZE lane addresses plus a lane-valid mask) through a valid/ready handshake, packs them into the buffer row format, and drives buffer write port A.
- The memShare read side consumes these rows and signals each row it reads with a pop pulse. The writer tracks occupancy so it never overwrites an unread row.

Parameters:
- SHARE_GROUP_SIZE, 5, lanes per request word.
- RQST_ADDR_BITWIDTH, 3, address bits per lane.
- MSGPASS_BUFF_RQST_WIDTH, RQST_ADDR_BITWIDTH+1, packed lane width; the lane MSB is the lane-valid flag.
- MSGPASS_BUFF_DEPTH, 8, buffer rows; does not need to be a power of 2.
- MSGPASS_BUFF_ADDR_WIDTH, $clog2(MSGPASS_BUFF_DEPTH), buffer address width.
- CNT_WIDTH, 8, frame entry-counter width.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_begin_i  in  1  start a frame; honoured only in IDLE.
- frame_end_i  in  1  close the frame; honoured only in ACTIVE.
- rqst_valid_i  in  1  request word valid.
- rqst_ready_o  out  1  writer can accept a word this cycle.
- rqst_addr_i  in  SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH  lane addresses; lane i occupies bits [(i+1)*W-1 : i*W].
- rqst_lane_mask_i  in  SHARE_GROUP_SIZE  per-lane valid.
- rd_pop_i  in  1  reader consumed one row.
- waddr_portA_o  out  MSGPASS_BUFF_ADDR_WIDTH  buffer write address.
- wdata_portA_o  out  SHARE_GROUP_SIZE*MSGPASS_BUFF_RQST_WIDTH  packed row.
- wen_portA_o  out  1  write enable, active LOW.
- full_o  out  1  occupancy equals DEPTH.
- empty_o  out  1  occupancy is 0.
- frame_done_o  out  1  one-cycle pulse at frame completion.
- entry_cnt_o  out  CNT_WIDTH  words accepted in the current or last frame.
- underflow_err_o  out  1  sticky: rd_pop_i was seen while empty.

Behaviour:
- Reset values: wen_portA_o=1, waddr_portA_o=0, wdata_portA_o=0, rqst_ready_o=0, full_o=0, empty_o=1, frame_done_o=0, entry_cnt_o=0, underflow_err_o=0. Internal state: FSM=IDLE, wptr=0, occupancy=0. Reset asserted mid-frame discards all state immediately.
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
  - IDLE: on frame_begin_i go to ACTIVE; clear wptr and entry_cnt_o. Occupancy is not cleared.
  - ACTIVE: on frame_end_i go to DRAIN. A word accepted in the same cycle as frame_end_i is part of the frame.
  - DRAIN: one cycle; go to DONE.
  - DONE: assert frame_done_o for exactly one cycle; go to IDLE.
- rqst_ready_o = (state==ACTIVE) && !full_o. It is decoded from registers only and has no combinational path from rqst_valid_i.
- Accept condition: rqst_valid_i && rqst_ready_o at a rising edge.
- Packing: lane i = {rqst_lane_mask_i[i], mask ? addr_lane_i : 0}.
- Write timing (latency 1): on an accept at edge T, from T until T+1 wen_portA_o=0, waddr_portA_o=wptr, wdata_portA_o=packed row. Otherwise wen_portA_o=1 and the address/data outputs hold their last values.
- On each accept: wptr increments with wrap from DEPTH-1 to 0; entry_cnt_o increments, saturating at 2^CNT_WIDTH-1.
- Occupancy updates:
  - +1 on accept, -1 on rd_pop_i.
  - Accept and pop in the same cycle leave occupancy unchanged.
  - A pop while empty is ignored and sets underflow_err_o. underflow_err_o clears only on rst.
- full_o and empty_o are registered from the next occupancy value, so they are valid in the cycle after the change. No write is issued while full_o=1.
- frame_begin_i outside IDLE is ignored. frame_end_i outside ACTIVE is ignored.

Test Plan:
- 1seq-2seq-2seq frame, mask=5'b11111, lane addrs {0,1,2,3,4}, then {4,3,2,1,0} twice, frame_end_i with the third word -> rows written at 0, 1, 2 with each lane MSB set; wen_portA_o low for 3 cycles; frame_done_o pulses 2 cycles after the last accept; entry_cnt_o=3.
- Mask 5'b10101, all addrs 7 -> lanes 0/2/4 = 4'b1111, lanes 1/3 = 4'b0000.
- Write 8 words with no pops -> full_o=1, rqst_ready_o=0, and no write on the 9th valid. One rd_pop_i -> ready reasserts the next cycle and the 9th word is written at address 0 (wrap).
- Occupancy 4, then accept and rd_pop_i in the same cycle -> occupancy stays 4; empty_o and full_o are unchanged.
- rd_pop_i while empty -> underflow_err_o=1, occupancy stays 0; the flag persists until rst.
- rst asserted mid-frame after 2 accepts -> all outputs at reset values asynchronously; a new frame_begin_i starts writing at address 0.
